// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
// Op encodings, sequencer states and counter sizing.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

  function automatic logic op_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-side request/response bundle of the mul/div unit.
// master = pipeline side, slave = mul/div unit.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             mf_req;
  logic             flush;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val,
    output hi_we, lo_we, wdata,
    output mf_req, flush,
    input  busy, done, stall, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val,
    input  hi_we, lo_we, wdata,
    input  mf_req, flush,
    output busy, done, stall, hi, lo
  );

endinterface

// File: rtl/muldiv_datapath.sv
// Combinational radix-2 step, operand magnitudes and sign fix-up
// for the mul/div sequencer.
module muldiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             sgn,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             sa,
  output logic             sb,
  output logic [WIDTH-1:0] mag_a,
  output logic [WIDTH-1:0] mag_b,
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] mreg,
  output logic [WIDTH-1:0] step_hi,
  output logic [WIDTH-1:0] step_lo,
  input  logic             neg_q,
  input  logic             neg_r,
  output logic [WIDTH-1:0] fix_hi,
  output logic [WIDTH-1:0] fix_lo
);

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shl;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] nprod;

  always_comb begin
    sa    = sgn & rs_val[WIDTH-1];
    sb    = sgn & rt_val[WIDTH-1];
    mag_a = sa ? -rs_val : rs_val;
    mag_b = sb ? -rt_val : rt_val;
  end

  // Remainder stays below the divisor, so diff[WIDTH] is a clean borrow.
  always_comb begin
    sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mreg} : '0);
    shl  = {acc_hi, acc_lo[WIDTH-1]};
    diff = shl - {1'b0, mreg};
    if (is_div) begin
      if (!diff[WIDTH]) begin
        step_hi = diff[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = shl[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = sum[WIDTH:1];
      step_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod  = {acc_hi, acc_lo};
    nprod = -prod;
    if (is_div) begin
      fix_hi = neg_r ? -acc_hi : acc_hi;
      fix_lo = neg_q ? -acc_lo : acc_lo;
    end else begin
      {fix_hi, fix_lo} = neg_q ? nprod : prod;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MIPS mul/div unit: FSM, operand/sign state,
// HI/LO registers and pipeline stall generation.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst_n,
  muldiv_sequencer_if.slave bus
);

  localparam int CW =
    (WIDTH == XLEN) ? CNT_W : $clog2(WIDTH);

  state_e           state;
  logic [CW-1:0]    cnt;
  logic             fix_ph;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] mreg;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;

  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;
  logic             div0;

  assign div0 = bus.op[1] && (bus.rt_val == '0);

  muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
    .sgn     (op_signed(bus.op)),
    .rs_val  (bus.rs_val),
    .rt_val  (bus.rt_val),
    .sa      (sa),
    .sb      (sb),
    .mag_a   (mag_a),
    .mag_b   (mag_b),
    .is_div  (is_div),
    .acc_hi  (acc_hi),
    .acc_lo  (acc_lo),
    .mreg    (mreg),
    .step_hi (step_hi),
    .step_lo (step_lo),
    .neg_q   (neg_q),
    .neg_r   (neg_r),
    .fix_hi  (fix_hi),
    .fix_lo  (fix_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      fix_ph <= 1'b0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      mreg   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush) begin
        state  <= IDLE;
        cnt    <= '0;
        fix_ph <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start) begin
              is_div <= bus.op[1];
              mreg   <= mag_b;
              fix_ph <= 1'b0;
              // Div-by-zero result is preloaded; fix-up is a no-op.
              if (div0) begin
                acc_hi <= bus.rs_val;
                acc_lo <= '1;
                neg_q  <= 1'b0;
                neg_r  <= 1'b0;
                state  <= FIX;
              end else begin
                acc_hi <= '0;
                acc_lo <= mag_a;
                neg_q  <= sa ^ sb;
                neg_r  <= sa;
                cnt    <= CW'(WIDTH - 1);
                state  <= RUN;
              end
            end else begin
              if (bus.hi_we) hi_q <= bus.wdata;
              if (bus.lo_we) lo_q <= bus.wdata;
            end
          end
          RUN: begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt - 1'b1;
            if (cnt == '0) state <= FIX;
          end
          FIX: begin
            if (!fix_ph) begin
              acc_hi <= fix_hi;
              acc_lo <= fix_lo;
              fix_ph <= 1'b1;
            end else begin
              hi_q   <= acc_hi;
              lo_q   <= acc_lo;
              done_q <= 1'b1;
              fix_ph <= 1'b0;
              state  <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.stall = bus.busy &
    (bus.mf_req | bus.start | bus.hi_we | bus.lo_we);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases plus
// random ops against an arithmetic reference model.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.WIDTH(W)) bus();

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] h,
                                output logic [31:0] l);
    longint p;
    longint q;
    longint r;
    logic [63:0] u;
    case (op)
      2'b00: begin
        p = longint'($signed(a)) * longint'($signed(b));
        u = p;
        h = u[63:32];
        l = u[31:0];
      end
      2'b01: begin
        u = {32'b0, a} * {32'b0, b};
        h = u[63:32];
        l = u[31:0];
      end
      2'b10: begin
        if (b == 0) begin
          h = a;
          l = '1;
        end else begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          h = r[31:0];
          l = q[31:0];
        end
      end
      default: begin
        if (b == 0) begin
          h = a;
          l = '1;
        end else begin
          h = a % b;
          l = a / b;
        end
      end
    endcase
  endfunction

  task automatic go(input logic [1:0] op,
                    input logic [31:0] a,
                    input logic [31:0] b);
    bus.op = op;
    bus.rs_val = a;
    bus.rt_val = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    for (int e = 1; e <= 200; e++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = e;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
    end
  endtask

  task automatic finish_check(input string tag,
                              input logic [1:0] op,
                              input logic [31:0] a,
                              input logic [31:0] b);
    int lat;
    bit bok;
    int exp_lat;
    wait_done(lat, bok);
    exp_lat = (op[1] && b == 0) ? 2 : W + 2;
    model(op, a, b, mhi, mlo);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_busy_run"}, 32'(bok), 1);
    chk({tag, "_busy_end"}, 32'(bus.busy), 0);
    chk({tag, "_hi"}, bus.hi, mhi);
    chk({tag, "_lo"}, bus.lo, mlo);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 32'(bus.done), 0);
  endtask

  task automatic run_check(input string tag,
                           input logic [1:0] op,
                           input logic [31:0] a,
                           input logic [31:0] b);
    go(op, a, b);
    finish_check(tag, op, a, b);
  endtask

  initial begin
    int lat;
    bit ok;
    bit seen;
    logic [1:0] rop;
    logic [31:0] ra;
    logic [31:0] rb;

    bus.start = 0;
    bus.op = 0;
    bus.rs_val = 0;
    bus.rt_val = 0;
    bus.hi_we = 0;
    bus.lo_we = 0;
    bus.wdata = 0;
    bus.mf_req = 0;
    bus.flush = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_stall", 32'(bus.stall), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_check("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd7);
    chk("mult_neg_hi_lit", bus.hi, 32'hFFFFFFFF);
    chk("mult_neg_lo_lit", bus.lo, 32'hFFFFFFEB);
    run_check("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_hi_lit", bus.hi, 32'hFFFFFFFE);
    run_check("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2);
    chk("div_neg_lo_lit", bus.lo, 32'hFFFFFFFD);
    run_check("divu", 2'b11, 32'd100, 32'd7);
    chk("divu_lo_lit", bus.lo, 32'd14);
    run_check("divu_zero", 2'b11, 32'd5, 32'd0);
    run_check("div_zero", 2'b10, 32'hFFFFFF00, 32'd0);
    run_check("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF);
    chk("div_ovf_lo_lit", bus.lo, 32'h80000000);

    // MTLO, then MTHI+MTLO together
    bus.lo_we = 1;
    bus.wdata = 32'h1234;
    @(posedge clk);
    #1;
    bus.lo_we = 0;
    chk("mtlo", bus.lo, 32'h1234);
    bus.hi_we = 1;
    bus.lo_we = 1;
    bus.wdata = 32'hCAFE;
    @(posedge clk);
    #1;
    bus.hi_we = 0;
    bus.lo_we = 0;
    chk("mt_both_hi", bus.hi, 32'hCAFE);
    chk("mt_both_lo", bus.lo, 32'hCAFE);

    // start wins over a same-cycle MTHI
    bus.hi_we = 1;
    bus.wdata = 32'hDEAD;
    go(2'b11, 32'd100, 32'd7);
    bus.hi_we = 0;
    chk("start_wins_hi", bus.hi, 32'hCAFE);
    finish_check("start_we", 2'b11, 32'd100, 32'd7);

    // stall while busy with MFHI and a queued op
    bus.op = 2'b00;
    bus.rs_val = 32'hFFFFFFFD;
    bus.rt_val = 32'd7;
    bus.start = 1;
    @(posedge clk);
    #1;
    bus.op = 2'b11;
    bus.rs_val = 32'd100;
    bus.rt_val = 32'd7;
    bus.mf_req = 1;
    ok = 1;
    lat = -1;
    for (int e = 1; e <= 200; e++) begin
      if (!bus.stall) ok = 0;
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = e;
        break;
      end
    end
    chk("stall_each_cycle", 32'(ok), 1);
    chk("stall_lat", lat, W + 2);
    chk("stall_drop", 32'(bus.stall), 0);
    model(2'b00, 32'hFFFFFFFD, 32'd7, mhi, mlo);
    chk("stall_first_hi", bus.hi, mhi);
    chk("stall_first_lo", bus.lo, mlo);
    @(posedge clk);
    #1;
    bus.start = 0;
    bus.mf_req = 0;
    chk("stall_second_acc", 32'(bus.busy), 1);
    finish_check("stall_second", 2'b11, 32'd100, 32'd7);

    // write while busy ignored, then flush mid-RUN
    go(2'b01, 32'h12345678, 32'h9ABCDEF0);
    repeat (5) @(posedge clk);
    #1;
    bus.hi_we = 1;
    bus.wdata = 32'h0BAD;
    #1;
    chk("stall_we", 32'(bus.stall), 1);
    @(posedge clk);
    #1;
    bus.hi_we = 0;
    repeat (3) @(posedge clk);
    #1;
    bus.flush = 1;
    @(posedge clk);
    #1;
    bus.flush = 0;
    chk("flush_busy", 32'(bus.busy), 0);
    chk("flush_hi", bus.hi, mhi);
    chk("flush_lo", bus.lo, mlo);
    seen = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk);
      #1;
      if (bus.done) seen = 1;
    end
    chk("flush_no_done", 32'(seen), 0);

    // async reset mid-RUN
    go(2'b00, 32'h7654321, 32'hFFFF0001);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("arst_hi", bus.hi, 0);
    chk("arst_lo", bus.lo, 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_done", 32'(bus.done), 0);
    #2;
    rst_n = 1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
      case ($urandom_range(0, 7))
        0: rb = 0;
        1: rb = $urandom_range(1, 15);
        2: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      run_check($sformatf("rnd%0d", i), rop, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Iterative multiply/divide unit with HI/LO registers for the MIPS pipeline, sitting beside the EX-stage ALU.
- Accepts MULT/MULTU/DIV/DIVU from EX and runs a radix-2 shift-add/restoring-subtract sequence over WIDTH cycles.
- Owns HI/LO and services MTHI/MTLO writes.
- Raises a stall toward the hazard logic while any HI/LO consumer or new mul/div op arrives during a busy operation.

Parameters:
WIDTH, 32, operand width; also the iteration count.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request a mul/div op this cycle
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
rs_val  in  WIDTH  multiplicand / dividend
rt_val  in  WIDTH  multiplier / divisor
hi_we  in  1  MTHI write
lo_we  in  1  MTLO write
wdata  in  WIDTH  MTHI/MTLO data
mf_req  in  1  MFHI/MFLO in EX this cycle
flush  in  1  synchronous abort of in-flight op
busy  out  1  operation in progress
done  out  1  one-cycle pulse, HI/LO just updated
stall  out  1  hold pipeline
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (rst_n low, async): state IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal regs=0. Reset mid-operation discards the op.
- States:
  - IDLE: start=1 latches operands and the op; clears both HI/LO write enables.
    - rt_val≠0, or a multiply: next state RUN, counter=WIDTH-1.
    - Divide with rt_val=0: next state FIX directly.
  - RUN: one iteration per cycle. Exits to FIX when counter=0.
  - FIX: apply signs, write hi/lo, done=1 on the next cycle, then IDLE.
- Latency: start sampled at edge 0 → RUN edges 1..WIDTH → FIX edge WIDTH+1. hi/lo/done valid after edge WIDTH+2; busy is high in between and falls in that same cycle. Div-by-zero: done after edge 2.
- Signed ops work on magnitudes; latched sign flags fix up in FIX.
- Multiply: {hi,lo} = 2*WIDTH-bit product, two's complement for MULT.
- Divide: lo = quotient, hi = remainder.
  - Quotient sign = xor of operand signs; remainder sign = dividend sign.
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0 (natural wrap, no trap).
  - Divide by zero (DIV and DIVU): hi=rs_val, lo=all ones.
- busy = (state≠IDLE).
- stall = busy & (mf_req | start | hi_we | lo_we), combinational. The held instruction re-presents itself and is accepted the cycle busy falls.
- HI/LO writes:
  - MTHI/MTLO in IDLE without start: hi/lo ← wdata at that edge.
  - hi_we and lo_we both high: both written.
  - start and hi_we/lo_we in the same IDLE cycle: start wins, the write is dropped.
  - Writes while busy: ignored; the pipeline is stalled anyway.
- flush: takes priority over everything except reset. Any state → IDLE at the next edge; hi/lo unchanged; done not pulsed. A flush coincident with start in IDLE cancels the start.
- done: register output, high exactly one cycle per completed op.

Decomposition:
- muldiv_pkg: op encodings (OP_MULT..OP_DIVU), state enum (IDLE, RUN, FIX), counter width constant clog2(WIDTH).
- Sub-module muldiv_datapath holds the combinational iteration step: conditional add/shift for multiply, trial subtract/shift for divide, and abs/negate helpers. muldiv_sequencer keeps the FSM, counter, operand/sign registers, HI/LO, and stall logic.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=7 → done after edge 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high through cycle 33.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=-7, rt=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/7 → lo=14, hi=2. DIVU 5/0 → done at edge 2, hi=5, lo=0xFFFFFFFF.
- mf_req=1 and a second start during RUN → stall=1 every busy cycle, second op ignored. Stall drops with busy, and the second op is accepted that cycle.
- MTLO wdata=0x1234 in IDLE → lo=0x1234. Then start+hi_we together → hi not written by hi_we; op result lands.
- flush at RUN cycle 10 → IDLE next edge, hi/lo retain prior values, no done. Async rst_n low mid-RUN → all outputs 0 immediately.
